// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - polynomial encodings, tap table and single-step LFSR helper
//
// Purpose : shared definitions for the parallel PRBS generator and checker.
// Contents: poly_sel encodings, (n,m) tap table, n-bit state mask,
//           reserved-code test and the one-bit Fibonacci step lfsr_step().
package prbs_pkg;

  localparam logic [2:0] POLY_PRBS7  = 3'd0;
  localparam logic [2:0] POLY_PRBS9  = 3'd1;
  localparam logic [2:0] POLY_PRBS11 = 3'd2;
  localparam logic [2:0] POLY_PRBS15 = 3'd3;
  localparam logic [2:0] POLY_PRBS23 = 3'd4;
  localparam logic [2:0] POLY_PRBS31 = 3'd5;

  typedef struct packed {
    logic [4:0] n;  // register length
    logic [4:0] m;  // second tap
  } taps_t;

  function automatic taps_t poly_taps(input logic [2:0] sel);
    taps_t t;
    case (sel)
      POLY_PRBS7:  t = '{n: 5'd7,  m: 5'd6};
      POLY_PRBS9:  t = '{n: 5'd9,  m: 5'd5};
      POLY_PRBS11: t = '{n: 5'd11, m: 5'd9};
      POLY_PRBS15: t = '{n: 5'd15, m: 5'd14};
      POLY_PRBS23: t = '{n: 5'd23, m: 5'd18};
      POLY_PRBS31: t = '{n: 5'd31, m: 5'd28};
      // Reserved codes get harmless in-range taps; their mask is zero and
      // generation is blocked by cfg_err anyway.
      default:     t = '{n: 5'd7,  m: 5'd6};
    endcase
    return t;
  endfunction

  // Low n bits set for the selected polynomial; zero for reserved codes.
  function automatic logic [31:0] poly_mask(input logic [2:0] sel);
    logic [31:0] msk;
    case (sel)
      POLY_PRBS7:  msk = 32'h0000_007F;
      POLY_PRBS9:  msk = 32'h0000_01FF;
      POLY_PRBS11: msk = 32'h0000_07FF;
      POLY_PRBS15: msk = 32'h0000_7FFF;
      POLY_PRBS23: msk = 32'h007F_FFFF;
      POLY_PRBS31: msk = 32'h7FFF_FFFF;
      default:     msk = 32'h0000_0000;
    endcase
    return msk;
  endfunction

  function automatic logic poly_reserved(input logic [2:0] sel);
    return (sel > POLY_PRBS31);
  endfunction

  // One Fibonacci step: returns {fb, next_state}; fb is the emitted bit.
  function automatic logic [32:0] lfsr_step(input logic [31:0] state,
                                            input logic [2:0]  sel);
    taps_t t;
    logic  fb;
    t  = poly_taps(sel);
    fb = state[t.n - 5'd1] ^ state[t.m - 5'd1];
    return {fb, ({state[30:0], fb} & poly_mask(sel))};
  endfunction

endpackage

// File: rtl/prbs_gen_par_if.sv
// rtl/prbs_gen_par_if.sv - valid/ready stream carrying PRBS words
//
// Purpose : groups the output stream of the PRBS generator.
// Signals : dout     DATA_W  PRBS word, bit 0 earliest in time
//           dout_vld 1       word valid
//           dout_rdy 1       sink accepts when dout_vld & dout_rdy
// Modports: master = source (generator), slave = sink.
interface prbs_gen_par_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_rdy;

  modport master (output dout, output dout_vld, input dout_rdy);
  modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/prbs_lfsr_unroll.sv
// rtl/prbs_lfsr_unroll.sv - combinational DATA_W-step LFSR unroll
//
// Purpose : advances the LFSR by DATA_W serial steps in one cycle.
// Ports   : state      in  32      current LFSR state
//           sel        in  3       polynomial select
//           word       out DATA_W  emitted bits, word[i] = bit of step i+1
//           next_state out 32      state after DATA_W steps
module prbs_lfsr_unroll
  import prbs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [31:0]       state,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] word,
  output logic [31:0]       next_state
);

  logic [31:0] s;
  logic [32:0] r;

  always_comb begin
    s    = state;
    r    = '0;
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r       = lfsr_step(s, sel);
      word[i] = r[32];
      s       = r[31:0];
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_gen_par.sv
// rtl/prbs_gen_par.sv - parallel run-time configurable PRBS generator
//
// Purpose : emits DATA_W PRBS bits per accepted beat, with polynomial
//           select, seed load, single-bit error injection and counters.
// Ports   : clk, rst          clock, async active-high reset
//           prbs_en           generate beats while high
//           poly_sel, seed    latched on seed_load pulse
//           seed_load         load pulse (priority over generation)
//           err_inj           flip bit 0 of the next generated beat
//           out_if            master stream (dout/dout_vld/dout_rdy)
//           cfg_err           latched poly is reserved, generation blocked
//           gen_shift_reg     LFSR state (debug)
//           word_cnt          accepted beats, wraps
//           inj_cnt           injected errors, saturates
module prbs_gen_par #(
  parameter int         DATA_W    = 8,
  parameter logic [2:0] INIT_POLY = 3'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prbs_en,
  input  logic [2:0]    poly_sel,
  input  logic          seed_load,
  input  logic [31:0]   seed,
  input  logic          err_inj,
  prbs_gen_par_if.master out_if,
  output logic          cfg_err,
  output logic [31:0]   gen_shift_reg,
  output logic [31:0]   word_cnt,
  output logic [15:0]   inj_cnt
);
  import prbs_pkg::*;

  logic [31:0]       state_q;
  logic [2:0]        poly_q;
  logic              cfg_err_q;
  logic [DATA_W-1:0] dout_q;
  logic              vld_q;
  logic              inj_pend_q;

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_inj;
  logic [31:0]       next_state;
  logic [31:0]       seed_masked;
  logic [31:0]       seed_val;
  logic              gen;
  logic              accept;
  logic              inj_now;

  prbs_lfsr_unroll #(.DATA_W(DATA_W)) u_unroll (
    .state      (state_q),
    .sel        (poly_q),
    .word       (word),
    .next_state (next_state)
  );

  assign accept = vld_q & out_if.dout_rdy;
  assign gen    = prbs_en & ~cfg_err_q & ~seed_load & (~vld_q | out_if.dout_rdy);
  // A pulse arriving in a generate cycle applies to that same beat.
  assign inj_now = inj_pend_q | err_inj;

  always_comb begin
    word_inj    = word;
    word_inj[0] = word[0] ^ inj_now;
    seed_masked = seed & poly_mask(poly_sel);
    // The all-zero state is the LFSR lock-up point, so map it to all-ones.
    seed_val    = (seed_masked == 32'd0) ? poly_mask(poly_sel) : seed_masked;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= poly_mask(INIT_POLY);
      poly_q     <= INIT_POLY;
      cfg_err_q  <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      inj_pend_q <= 1'b0;
      word_cnt   <= 32'd0;
      inj_cnt    <= 16'd0;
    end else begin
      if (seed_load) begin
        poly_q    <= poly_sel;
        cfg_err_q <= poly_reserved(poly_sel);
        state_q   <= seed_val;
        // The pending beat stays on dout unless it is taken right now.
        if (accept) vld_q <= 1'b0;
      end else if (gen) begin
        dout_q  <= word_inj;
        vld_q   <= 1'b1;
        state_q <= next_state;
      end else if (accept) begin
        vld_q <= 1'b0;
      end

      if (gen) begin
        inj_pend_q <= 1'b0;
        if (inj_now && inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
      end else if (err_inj) begin
        inj_pend_q <= 1'b1;
      end

      if (accept) word_cnt <= word_cnt + 32'd1;
    end
  end

  assign out_if.dout     = dout_q;
  assign out_if.dout_vld = vld_q;
  assign cfg_err         = cfg_err_q;
  assign gen_shift_reg   = state_q;

endmodule

// File: tb/tb_prbs_gen_par.sv
// tb/tb_prbs_gen_par.sv - directed self-checking bench for prbs_gen_par
module tb_prbs_gen_par;

  logic        clk = 1'b0;
  logic        rst;
  logic        prbs_en;
  logic [2:0]  poly_sel;
  logic        seed_load;
  logic [31:0] seed;
  logic        err_inj;
  logic        cfg_err;
  logic [31:0] gen_shift_reg;
  logic [31:0] word_cnt;
  logic [15:0] inj_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] ms;
  logic [7:0]  w;

  prbs_gen_par_if #(.DATA_W(8)) s_if ();

  prbs_gen_par #(.DATA_W(8), .INIT_POLY(3'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .prbs_en       (prbs_en),
    .poly_sel      (poly_sel),
    .seed_load     (seed_load),
    .seed          (seed),
    .err_inj       (err_inj),
    .out_if        (s_if.master),
    .cfg_err       (cfg_err),
    .gen_shift_reg (gen_shift_reg),
    .word_cnt      (word_cnt),
    .inj_cnt       (inj_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Serial reference: one Fibonacci step per bit, 8 bits per beat.
  function automatic logic [7:0] mbeat(input logic [31:0] s_in, input int n, input int m,
                                       output logic [31:0] s_out);
    logic [31:0] s;
    logic [31:0] msk;
    logic        fb;
    logic [7:0]  wd;
    s   = s_in;
    msk = (32'h1 << n) - 32'h1;
    wd  = '0;
    for (int i = 0; i < 8; i++) begin
      fb    = s[5'(n - 1)] ^ s[5'(m - 1)];
      wd[i] = fb;
      s     = {s[30:0], fb} & msk;
    end
    s_out = s;
    return wd;
  endfunction

  initial begin
    rst = 1'b1; prbs_en = 1'b0; poly_sel = 3'd0; seed_load = 1'b0;
    seed = 32'd0; err_inj = 1'b0; s_if.dout_rdy = 1'b0;

    // Reset state
    tick();
    chk("rst_vld",   32'(s_if.dout_vld), 32'd0);
    chk("rst_dout",  32'(s_if.dout), 32'd0);
    chk("rst_state", gen_shift_reg, 32'h7F);
    chk("rst_cfg",   32'(cfg_err), 32'd0);
    chk("rst_wcnt",  word_cnt, 32'd0);
    chk("rst_icnt",  32'(inj_cnt), 32'd0);

    // PRBS7 free run, full period
    rst = 1'b0; prbs_en = 1'b1; s_if.dout_rdy = 1'b1;
    ms = 32'h7F;
    for (int k = 1; k <= 127; k++) begin
      tick();
      w = mbeat(ms, 7, 6, ms);
      chk("t1_dout", 32'(s_if.dout), 32'(w));
      chk("t1_vld", 32'(s_if.dout_vld), 32'd1);
      chk("t1_nonzero", 32'(gen_shift_reg != 32'd0), 32'd1);
      if (k == 1) chk("t1_first", 32'(s_if.dout), 32'h40);
      if (k == 2) chk("t1_second", 32'(s_if.dout), 32'h30);
    end
    chk("t1_period", gen_shift_reg, 32'h7F);
    chk("t1_wcnt", word_cnt, 32'd126);
    prbs_en = 1'b0;
    tick();
    chk("t1_drain_vld", 32'(s_if.dout_vld), 32'd0);
    chk("t1_drain_wcnt", word_cnt, 32'd127);

    // Zero seed maps to all-ones
    seed_load = 1'b1; seed = 32'd0; poly_sel = 3'd0;
    tick();
    seed_load = 1'b0;
    chk("t2_state", gen_shift_reg, 32'h7F);
    chk("t2_vld", 32'(s_if.dout_vld), 32'd0);
    prbs_en = 1'b1;
    tick();
    chk("t2_dout", 32'(s_if.dout), 32'h40);
    chk("t2_vld1", 32'(s_if.dout_vld), 32'd1);
    prbs_en = 1'b0;
    tick();
    chk("t2_vld0", 32'(s_if.dout_vld), 32'd0);
    chk("t2_wcnt", word_cnt, 32'd128);

    // Injection before the first beat
    seed_load = 1'b1; seed = 32'h7F;
    tick();
    seed_load = 1'b0; err_inj = 1'b1;
    tick();
    err_inj = 1'b0; prbs_en = 1'b1;
    tick();
    chk("t3_dout", 32'(s_if.dout), 32'h41);
    chk("t3_icnt", 32'(inj_cnt), 32'd1);
    chk("t3_state", gen_shift_reg, 32'h02);
    tick();
    chk("t3_dout2", 32'(s_if.dout), 32'h30);
    chk("t3_icnt2", 32'(inj_cnt), 32'd1);
    chk("t3_wcnt", word_cnt, 32'd129);

    // Backpressure for 5 cycles
    s_if.dout_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_dout", 32'(s_if.dout), 32'h30);
      chk("t4_hold_vld", 32'(s_if.dout_vld), 32'd1);
      chk("t4_hold_state", gen_shift_reg, 32'h0C);
      chk("t4_hold_wcnt", word_cnt, 32'd129);
    end
    s_if.dout_rdy = 1'b1;
    ms = 32'h0C;
    for (int j = 1; j <= 4; j++) begin
      tick();
      w = mbeat(ms, 7, 6, ms);
      chk("t4_resume", 32'(s_if.dout), 32'(w));
      chk("t4_wcnt", word_cnt, 32'(129 + j));
    end

    // Reserved polynomial, then PRBS31
    seed_load = 1'b1; poly_sel = 3'd6; seed = 32'h1234;
    tick();
    seed_load = 1'b0;
    chk("t5_cfg1", 32'(cfg_err), 32'd1);
    chk("t5_vld0", 32'(s_if.dout_vld), 32'd0);
    chk("t5_wcnt", word_cnt, 32'd134);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_blocked", 32'(s_if.dout_vld), 32'd0);
      chk("t5_cfg_hold", 32'(cfg_err), 32'd1);
    end
    seed_load = 1'b1; poly_sel = 3'd5; seed = 32'hFFFF_FFFF;
    tick();
    seed_load = 1'b0;
    chk("t5_cfg0", 32'(cfg_err), 32'd0);
    chk("t5_state31", gen_shift_reg, 32'h7FFF_FFFF);
    chk("t5_vld_load", 32'(s_if.dout_vld), 32'd0);
    ms = 32'h7FFF_FFFF;
    tick();
    w = mbeat(ms, 31, 28, ms);
    chk("t5_first31", 32'(s_if.dout), 32'h00);
    chk("t5_first31_model", 32'(s_if.dout), 32'(w));
    tick();
    w = mbeat(ms, 31, 28, ms);
    chk("t5_next31", 32'(s_if.dout), 32'(w));
    chk("t5_state_next", gen_shift_reg, ms);

    // Reset mid-stream under backpressure
    s_if.dout_rdy = 1'b0;
    tick();
    chk("t6_pending", 32'(s_if.dout_vld), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_vld", 32'(s_if.dout_vld), 32'd0);
    chk("t6_dout", 32'(s_if.dout), 32'd0);
    chk("t6_wcnt", word_cnt, 32'd0);
    chk("t6_icnt", 32'(inj_cnt), 32'd0);
    chk("t6_state", gen_shift_reg, 32'h7F);
    chk("t6_cfg", 32'(cfg_err), 32'd0);
    tick();
    rst = 1'b0; s_if.dout_rdy = 1'b1; prbs_en = 1'b1;
    ms = 32'h7F;
    tick();
    w = mbeat(ms, 7, 6, ms);
    chk("t6_restart", 32'(s_if.dout), 32'h40);

    // Injection in a generate cycle applies to that beat
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    w = mbeat(ms, 7, 6, ms);
    chk("t7_inj_gen", 32'(s_if.dout), 32'(w ^ 8'h01));
    chk("t7_icnt", 32'(inj_cnt), 32'd1);
    tick();
    w = mbeat(ms, 7, 6, ms);
    chk("t7_clean", 32'(s_if.dout), 32'(w));
    chk("t7_icnt_hold", 32'(inj_cnt), 32'd1);

    // Repeated pulse while pending counts once
    prbs_en = 1'b0; err_inj = 1'b1;
    tick();
    tick();
    err_inj = 1'b0; prbs_en = 1'b1;
    tick();
    w = mbeat(ms, 7, 6, ms);
    chk("t8_inj_once", 32'(s_if.dout), 32'(w ^ 8'h01));
    chk("t8_icnt", 32'(inj_cnt), 32'd2);
    tick();
    w = mbeat(ms, 7, 6, ms);
    chk("t8_clean", 32'(s_if.dout), 32'(w));
    chk("t8_icnt_hold", 32'(inj_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
